// File: rtl/if_fetch_stage.sv
// ---------------------------------------------------------------------------
// if_fetch_stage
//
// Instruction-fetch stage: the PC register, a word-organised instruction
// memory addressed by byte PC (word index = PC >> 2), and the IF/ID pipeline
// register that feeds decode. Supports branch redirect, stall, flush and a
// synchronous memory load port. A misaligned or out-of-range fetch address
// parks the stage in HALT until reset.
//
// State table
//   state  | meaning
//   RUN    | normal fetch, redirect, stall and flush handling
//   HALT   | fetch-address error seen; all outputs frozen until RST
//
// Ports
//   CLK           in   clock, all state updates on posedge
//   RST           in   asynchronous active-high reset
//   PC_SRC        in   load BRANCH_ADR into the PC this edge
//   BRANCH_ADR    in   redirect target (byte address)
//   STALL         in   hold PC and IF/ID outputs
//   FLUSH         in   squash IF/ID contents to a bubble
//   INS_WE        in   instruction memory write enable
//   INS_WADR      in   instruction memory write word index
//   INS_WDATA     in   instruction memory write data
//   NEXT_INS_ADR  out  registered fetched PC + PC_STEP
//   CUR_INS       out  registered fetched instruction
//   IF_VALID      out  CUR_INS / NEXT_INS_ADR hold a real instruction
//   PC_OUT        out  current PC (debug)
//   ADR_ERR       out  sticky fetch-address error, 1 while in HALT
// ---------------------------------------------------------------------------
module if_fetch_stage #(
  parameter int          ADDR_W    = 32,
  parameter int          DATA_W    = 32,
  parameter int          MEM_DEPTH = 4096,
  parameter int unsigned RESET_PC  = 0,
  parameter int unsigned PC_STEP   = 4,
  localparam int         IDX_W     = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              PC_SRC,
  input  logic [ADDR_W-1:0] BRANCH_ADR,
  input  logic              STALL,
  input  logic              FLUSH,
  input  logic              INS_WE,
  input  logic [IDX_W-1:0]  INS_WADR,
  input  logic [DATA_W-1:0] INS_WDATA,
  output logic [ADDR_W-1:0] NEXT_INS_ADR,
  output logic [DATA_W-1:0] CUR_INS,
  output logic              IF_VALID,
  output logic [ADDR_W-1:0] PC_OUT,
  output logic              ADR_ERR
);

  localparam logic [ADDR_W-1:0] RESET_PC_C = ADDR_W'(RESET_PC);
  localparam logic [ADDR_W-1:0] PC_STEP_C  = ADDR_W'(PC_STEP);
  localparam logic [ADDR_W-1:0] DEPTH_A_C  = ADDR_W'(MEM_DEPTH);
  localparam logic [IDX_W:0]    DEPTH_W_C  = (IDX_W+1)'(MEM_DEPTH);

  typedef enum logic {
    S_RUN  = 1'b0,
    S_HALT = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] cur_ins_q, cur_ins_d;
  logic [ADDR_W-1:0] next_adr_q, next_adr_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;

  logic [DATA_W-1:0] mem_q [MEM_DEPTH];

  logic [ADDR_W-1:0] word_idx;
  logic [ADDR_W-1:0] pc_plus;
  logic [DATA_W-1:0] rd_data;
  logic              fetch_req;
  logic              fetch_err;
  logic              wr_ok;

  // ---------------------------------------------------------------------
  // Fetch address decode
  // ---------------------------------------------------------------------
  assign word_idx  = pc_q >> 2;
  assign pc_plus   = pc_q + PC_STEP_C;     // modulo 2^ADDR_W, wrap is legal
  assign fetch_req = (state_q == S_RUN) && !STALL && !FLUSH;
  // Only a real fetch can raise an error; stalled/flushed cycles never do.
  assign fetch_err = fetch_req && ((pc_q[1:0] != 2'b00) || (word_idx >= DEPTH_A_C));

  // Asynchronous array read sampled into CUR_INS at the edge; a write to the
  // same word on that edge lands via NBA, so the old data is returned.
  assign rd_data = mem_q[word_idx[IDX_W-1:0]];

  // ---------------------------------------------------------------------
  // Instruction memory (not reset)
  // ---------------------------------------------------------------------
  assign wr_ok = ({1'b0, INS_WADR} < DEPTH_W_C);

  always_ff @(posedge CLK) begin
    if (INS_WE && wr_ok) begin
      mem_q[INS_WADR] <= INS_WDATA;
    end
  end

  // ---------------------------------------------------------------------
  // State and pipeline registers
  // ---------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= S_RUN;
      pc_q       <= RESET_PC_C;
      cur_ins_q  <= '0;
      next_adr_q <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      cur_ins_q  <= cur_ins_d;
      next_adr_q <= next_adr_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
    end
  end

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RUN:   if (fetch_err) state_d = S_HALT;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_RUN;
    endcase
  end

  // ---------------------------------------------------------------------
  // Output / datapath next-value logic
  // ---------------------------------------------------------------------
  always_comb begin
    pc_d       = pc_q;
    cur_ins_d  = cur_ins_q;
    next_adr_d = next_adr_q;
    valid_d    = valid_q;
    err_d      = err_q;

    if (state_q == S_RUN) begin
      // IF/ID register: FLUSH > STALL > fetch
      if (FLUSH) begin
        cur_ins_d  = '0;
        next_adr_d = '0;
        valid_d    = 1'b0;
      end else if (STALL) begin
        cur_ins_d  = cur_ins_q;
      end else if (fetch_err) begin
        cur_ins_d  = '0;
        valid_d    = 1'b0;
        err_d      = 1'b1;
      end else begin
        cur_ins_d  = rd_data;
        next_adr_d = pc_plus;
        valid_d    = 1'b1;
      end

      // PC: a faulting fetch freezes the PC; otherwise PC_SRC > STALL > +step.
      // The redirect wins over STALL and FLUSH so it is never lost.
      if (fetch_err) begin
        pc_d = pc_q;
      end else if (PC_SRC) begin
        pc_d = BRANCH_ADR;
      end else if (STALL) begin
        pc_d = pc_q;
      end else begin
        pc_d = pc_plus;
      end
    end
  end

  assign NEXT_INS_ADR = next_adr_q;
  assign CUR_INS      = cur_ins_q;
  assign IF_VALID     = valid_q;
  assign PC_OUT       = pc_q;
  assign ADR_ERR      = err_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
module tb_if_fetch_stage;

  localparam int ADDR_W    = 32;
  localparam int DATA_W    = 32;
  localparam int MEM_DEPTH = 4096;
  localparam int IDX_W     = 12;

  localparam logic [31:0] INS_A  = 32'hA000_000A;
  localparam logic [31:0] INS_B  = 32'hB000_000B;
  localparam logic [31:0] INS_C  = 32'hC000_000C;
  localparam logic [31:0] INS_D  = 32'hD000_000D;
  localparam logic [31:0] INS_E  = 32'hE000_000E;
  localparam logic [31:0] OLD5   = 32'h5555_0005;
  localparam logic [31:0] INS_G  = 32'h6666_0006;
  localparam logic [31:0] INS_Q  = 32'h1616_0016;
  localparam logic [31:0] NEW_X  = 32'hDEAD_BEEF;

  logic              CLK;
  logic              RST;
  logic              PC_SRC;
  logic [ADDR_W-1:0] BRANCH_ADR;
  logic              STALL;
  logic              FLUSH;
  logic              INS_WE;
  logic [IDX_W-1:0]  INS_WADR;
  logic [DATA_W-1:0] INS_WDATA;
  logic [ADDR_W-1:0] NEXT_INS_ADR;
  logic [DATA_W-1:0] CUR_INS;
  logic              IF_VALID;
  logic [ADDR_W-1:0] PC_OUT;
  logic              ADR_ERR;

  int errors = 0;
  int checks = 0;

  if_fetch_stage #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_DEPTH(MEM_DEPTH),
    .RESET_PC(0), .PC_STEP(4)
  ) dut (
    .CLK(CLK), .RST(RST), .PC_SRC(PC_SRC), .BRANCH_ADR(BRANCH_ADR),
    .STALL(STALL), .FLUSH(FLUSH), .INS_WE(INS_WE), .INS_WADR(INS_WADR),
    .INS_WDATA(INS_WDATA), .NEXT_INS_ADR(NEXT_INS_ADR), .CUR_INS(CUR_INS),
    .IF_VALID(IF_VALID), .PC_OUT(PC_OUT), .ADR_ERR(ADR_ERR)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs;
    PC_SRC = 1'b0; BRANCH_ADR = '0; STALL = 1'b0; FLUSH = 1'b0;
    INS_WE = 1'b0; INS_WADR = '0; INS_WDATA = '0;
  endtask

  task automatic reset_pulse;
    RST = 1'b1;
    #2;
    RST = 1'b0;
  endtask

  task automatic test_reset;
    logic [IDX_W-1:0]  adr [8];
    logic [DATA_W-1:0] dat [8];
    adr = '{12'd0, 12'd1, 12'd2, 12'd3, 12'd4, 12'd5, 12'd6, 12'd16};
    dat = '{INS_A, INS_B, INS_C, INS_D, INS_E, OLD5, INS_G, INS_Q};
    RST = 1'b1;
    for (int i = 0; i < 8; i++) begin
      INS_WE = 1'b1; INS_WADR = adr[i]; INS_WDATA = dat[i];
      tick();
    end
    INS_WE = 1'b0;
    checks++; if (PC_OUT !== 32'd0) begin errors++; $display("FAIL reset_pc got %h exp %h", PC_OUT, 32'd0); end
    checks++; if (CUR_INS !== 32'd0) begin errors++; $display("FAIL reset_cur got %h exp %h", CUR_INS, 32'd0); end
    checks++; if (NEXT_INS_ADR !== 32'd0) begin errors++; $display("FAIL reset_next got %h exp %h", NEXT_INS_ADR, 32'd0); end
    checks++; if (IF_VALID !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", IF_VALID); end
    checks++; if (ADR_ERR !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", ADR_ERR); end
    RST = 1'b0;
  endtask

  task automatic test_sequential;
    logic [DATA_W-1:0] exp_ins [4];
    exp_ins = '{INS_A, INS_B, INS_C, INS_D};
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (CUR_INS !== exp_ins[i]) begin errors++; $display("FAIL seq_cur[%0d] got %h exp %h", i, CUR_INS, exp_ins[i]); end
      checks++; if (NEXT_INS_ADR !== 32'(4*(i+1))) begin errors++; $display("FAIL seq_next[%0d] got %h exp %h", i, NEXT_INS_ADR, 4*(i+1)); end
      checks++; if (PC_OUT !== 32'(4*(i+1))) begin errors++; $display("FAIL seq_pc[%0d] got %h exp %h", i, PC_OUT, 4*(i+1)); end
      checks++; if (IF_VALID !== 1'b1) begin errors++; $display("FAIL seq_valid[%0d] got %b exp 1", i, IF_VALID); end
    end
  endtask

  task automatic test_stall;
    reset_pulse();
    tick();
    tick();
    STALL = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (CUR_INS !== INS_B) begin errors++; $display("FAIL stall_cur[%0d] got %h exp %h", i, CUR_INS, INS_B); end
      checks++; if (NEXT_INS_ADR !== 32'd8) begin errors++; $display("FAIL stall_next[%0d] got %h exp 8", i, NEXT_INS_ADR); end
      checks++; if (PC_OUT !== 32'd8) begin errors++; $display("FAIL stall_pc[%0d] got %h exp 8", i, PC_OUT); end
    end
    STALL = 1'b0;
    tick();
    checks++; if (CUR_INS !== INS_C) begin errors++; $display("FAIL stall_rel_cur got %h exp %h", CUR_INS, INS_C); end
    checks++; if (NEXT_INS_ADR !== 32'd12) begin errors++; $display("FAIL stall_rel_next got %h exp c", NEXT_INS_ADR); end
  endtask

  task automatic test_branch_flush;
    for (int rep = 0; rep < 2; rep++) begin
      PC_SRC = 1'b1; BRANCH_ADR = 32'h40; FLUSH = 1'b1; STALL = (rep == 1);
      tick();
      clear_inputs();
      checks++; if (IF_VALID !== 1'b0) begin errors++; $display("FAIL brf_valid[%0d] got %b exp 0", rep, IF_VALID); end
      checks++; if (CUR_INS !== 32'd0) begin errors++; $display("FAIL brf_cur[%0d] got %h exp 0", rep, CUR_INS); end
      checks++; if (NEXT_INS_ADR !== 32'd0) begin errors++; $display("FAIL brf_next[%0d] got %h exp 0", rep, NEXT_INS_ADR); end
      checks++; if (PC_OUT !== 32'h40) begin errors++; $display("FAIL brf_pc[%0d] got %h exp 40", rep, PC_OUT); end
      tick();
      checks++; if (CUR_INS !== INS_Q) begin errors++; $display("FAIL brf_tgt_cur[%0d] got %h exp %h", rep, CUR_INS, INS_Q); end
      checks++; if (NEXT_INS_ADR !== 32'h44) begin errors++; $display("FAIL brf_tgt_next[%0d] got %h exp 44", rep, NEXT_INS_ADR); end
      checks++; if (IF_VALID !== 1'b1) begin errors++; $display("FAIL brf_tgt_valid[%0d] got %b exp 1", rep, IF_VALID); end
      checks++; if (PC_OUT !== 32'h44) begin errors++; $display("FAIL brf_tgt_pc[%0d] got %h exp 44", rep, PC_OUT); end
    end
  endtask

  task automatic test_read_during_write;
    PC_SRC = 1'b1; BRANCH_ADR = 32'd20; FLUSH = 1'b1;
    tick();
    clear_inputs();
    INS_WE = 1'b1; INS_WADR = 12'd5; INS_WDATA = NEW_X;
    tick();
    clear_inputs();
    checks++; if (CUR_INS !== OLD5) begin errors++; $display("FAIL rdw_old got %h exp %h", CUR_INS, OLD5); end
    checks++; if (NEXT_INS_ADR !== 32'd24) begin errors++; $display("FAIL rdw_next got %h exp 18", NEXT_INS_ADR); end
    PC_SRC = 1'b1; BRANCH_ADR = 32'd20; FLUSH = 1'b1;
    tick();
    clear_inputs();
    tick();
    checks++; if (CUR_INS !== NEW_X) begin errors++; $display("FAIL rdw_new got %h exp %h", CUR_INS, NEW_X); end
    checks++; if (PC_OUT !== 32'd24) begin errors++; $display("FAIL rdw_pc got %h exp 18", PC_OUT); end
  endtask

  task automatic test_misaligned;
    PC_SRC = 1'b1; BRANCH_ADR = 32'h42;
    tick();
    clear_inputs();
    checks++; if (CUR_INS !== INS_G) begin errors++; $display("FAIL mis_samecycle_cur got %h exp %h", CUR_INS, INS_G); end
    checks++; if (PC_OUT !== 32'h42) begin errors++; $display("FAIL mis_load_pc got %h exp 42", PC_OUT); end
    checks++; if (ADR_ERR !== 1'b0) begin errors++; $display("FAIL mis_load_err got %b exp 0", ADR_ERR); end
    tick();
    checks++; if (ADR_ERR !== 1'b1) begin errors++; $display("FAIL mis_err got %b exp 1", ADR_ERR); end
    checks++; if (IF_VALID !== 1'b0) begin errors++; $display("FAIL mis_valid got %b exp 0", IF_VALID); end
    checks++; if (CUR_INS !== 32'd0) begin errors++; $display("FAIL mis_cur got %h exp 0", CUR_INS); end
    checks++; if (NEXT_INS_ADR !== 32'd28) begin errors++; $display("FAIL mis_next_hold got %h exp 1c", NEXT_INS_ADR); end
    checks++; if (PC_OUT !== 32'h42) begin errors++; $display("FAIL mis_pc got %h exp 42", PC_OUT); end
    PC_SRC = 1'b1; BRANCH_ADR = 32'd0; STALL = 1'b1; FLUSH = 1'b1;
    tick();
    tick();
    clear_inputs();
    checks++; if (PC_OUT !== 32'h42) begin errors++; $display("FAIL halt_pc got %h exp 42", PC_OUT); end
    checks++; if (NEXT_INS_ADR !== 32'd28) begin errors++; $display("FAIL halt_next got %h exp 1c", NEXT_INS_ADR); end
    checks++; if (ADR_ERR !== 1'b1) begin errors++; $display("FAIL halt_err got %b exp 1", ADR_ERR); end
    RST = 1'b1;
    #2;
    checks++; if (ADR_ERR !== 1'b0) begin errors++; $display("FAIL halt_rst_err got %b exp 0", ADR_ERR); end
    checks++; if (PC_OUT !== 32'd0) begin errors++; $display("FAIL halt_rst_pc got %h exp 0", PC_OUT); end
    RST = 1'b0;
  endtask

  task automatic test_out_of_range;
    PC_SRC = 1'b1; BRANCH_ADR = 32'(4*MEM_DEPTH);
    tick();
    clear_inputs();
    checks++; if (CUR_INS !== INS_A) begin errors++; $display("FAIL oor_samecycle_cur got %h exp %h", CUR_INS, INS_A); end
    checks++; if (PC_OUT !== 32'h4000) begin errors++; $display("FAIL oor_load_pc got %h exp 4000", PC_OUT); end
    tick();
    tick();
    checks++; if (ADR_ERR !== 1'b1) begin errors++; $display("FAIL oor_err got %b exp 1", ADR_ERR); end
    checks++; if (IF_VALID !== 1'b0) begin errors++; $display("FAIL oor_valid got %b exp 0", IF_VALID); end
    checks++; if (NEXT_INS_ADR !== 32'd4) begin errors++; $display("FAIL oor_next got %h exp 4", NEXT_INS_ADR); end
    checks++; if (PC_OUT !== 32'h4000) begin errors++; $display("FAIL oor_pc got %h exp 4000", PC_OUT); end
    reset_pulse();
  endtask

  task automatic test_async_reset;
    tick();
    tick();
    checks++; if (PC_OUT !== 32'd8) begin errors++; $display("FAIL arst_pre_pc got %h exp 8", PC_OUT); end
    #2;
    RST = 1'b1;
    #1;
    checks++; if (PC_OUT !== 32'd0) begin errors++; $display("FAIL arst_pc got %h exp 0", PC_OUT); end
    checks++; if (CUR_INS !== 32'd0) begin errors++; $display("FAIL arst_cur got %h exp 0", CUR_INS); end
    checks++; if (NEXT_INS_ADR !== 32'd0) begin errors++; $display("FAIL arst_next got %h exp 0", NEXT_INS_ADR); end
    checks++; if (IF_VALID !== 1'b0) begin errors++; $display("FAIL arst_valid got %b exp 0", IF_VALID); end
    #1;
    RST = 1'b0;
    tick();
    checks++; if (CUR_INS !== INS_A) begin errors++; $display("FAIL arst_restart_cur got %h exp %h", CUR_INS, INS_A); end
    checks++; if (NEXT_INS_ADR !== 32'd4) begin errors++; $display("FAIL arst_restart_next got %h exp 4", NEXT_INS_ADR); end
    checks++; if (PC_OUT !== 32'd4) begin errors++; $display("FAIL arst_restart_pc got %h exp 4", PC_OUT); end
  endtask

  initial begin
    RST = 1'b1;
    clear_inputs();
    test_reset();
    test_sequential();
    test_stall();
    test_branch_flush();
    test_read_during_write();
    test_misaligned();
    test_out_of_range();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Parametrised instruction-fetch stage with an IF/ID pipeline register.
- Holds the PC and a word-organised instruction memory addressed by byte PC (index = PC >> 2).
- Redirects to a branch target, and supports stall, flush and a synchronous memory load port.
- Detects misaligned or out-of-range fetch addresses and halts until reset. Feeds the decode stage.

Parameters:
- ADDR_W, 32, PC / address width in bits.
- DATA_W, 32, instruction width in bits.
- MEM_DEPTH, 4096, instruction memory depth in words.
- RESET_PC, 0, PC value after reset; must be 4-byte aligned.
- PC_STEP, 4, PC increment per fetch, in bytes.

Ports:
- CLK  in  1  clock; all state updates on posedge.
- RST  in  1  asynchronous, active-high reset.
- PC_SRC  in  1  1 = load BRANCH_ADR into PC this edge.
- BRANCH_ADR  in  ADDR_W  redirect target (byte address).
- STALL  in  1  hold PC and IF/ID outputs.
- FLUSH  in  1  squash IF/ID contents to a bubble.
- INS_WE  in  1  instruction memory write enable.
- INS_WADR  in  clog2(MEM_DEPTH)  write word index.
- INS_WDATA  in  DATA_W  write data.
- NEXT_INS_ADR  out  ADDR_W  registered fetched PC + PC_STEP.
- CUR_INS  out  DATA_W  registered fetched instruction.
- IF_VALID  out  1  CUR_INS/NEXT_INS_ADR hold a real instruction.
- PC_OUT  out  ADDR_W  current PC (debug).
- ADR_ERR  out  1  sticky fetch-address error; 1 while in HALT.

Behaviour:
- Reset (async, any time, including mid-operation):
  - PC=RESET_PC; CUR_INS=0; NEXT_INS_ADR=0; IF_VALID=0; ADR_ERR=0; state=RUN.
  - Memory contents are not reset.
- States: RUN, HALT. RUN->HALT on a fetch error. HALT is left only by RST.
- "Fetch" = a posedge in RUN with STALL=0 and FLUSH=0. Latency is one cycle:
  - CUR_INS <= MEM[PC>>2].
  - NEXT_INS_ADR <= PC+PC_STEP.
  - IF_VALID <= 1.
- Fetch error: at a fetch edge, if PC[1:0]!=0 or (PC>>2)>=MEM_DEPTH:
  - CUR_INS<=0, IF_VALID<=0, NEXT_INS_ADR holds.
  - ADR_ERR<=1, state<=HALT, PC holds.
  - Squashed or stalled cycles never raise an error.
- IF/ID output priority (RUN): FLUSH > STALL > fetch.
  - FLUSH=1: CUR_INS<=0, NEXT_INS_ADR<=0, IF_VALID<=0 (regardless of STALL).
  - STALL=1, FLUSH=0: all outputs hold.
- PC update priority (RUN): PC_SRC > STALL > increment.
  - PC_SRC=1: PC<=BRANCH_ADR, even when STALL=1 or FLUSH=1; the redirect is never lost.
  - Else STALL=1: PC holds.
  - Else: PC<=PC+PC_STEP (FLUSH alone does not stop the increment).
- The instruction fetched in the same cycle as PC_SRC=1 is still delivered. Squashing wrong-path instructions is done with FLUSH, driven by hazard control.
- Arithmetic: PC+PC_STEP is modulo 2^ADDR_W; wrap to 0 is legal. Out-of-range is then caught by the fetch-error check.
- BRANCH_ADR is not checked at load; it is checked when fetched.
- HALT: PC, CUR_INS=0, IF_VALID=0 and ADR_ERR=1 are all frozen. PC_SRC, STALL and FLUSH are ignored.
- Memory write:
  - INS_WE=1 writes MEM[INS_WADR]<=INS_WDATA at posedge, in any state.
  - Read-during-write to the same word returns the old data; the new data is visible from the next edge.
  - Writes with INS_WADR>=MEM_DEPTH are dropped.
- PC_OUT = PC register, combinational from the register.

Test Plan:
- Preload MEM[0..3]=A,B,C,D; release RST -> edges 1..4 give CUR_INS=A,B,C,D; NEXT_INS_ADR=4,8,12,16; IF_VALID=1; PC_OUT=4,8,12,16.
- STALL=1 for 3 cycles after fetching B -> CUR_INS=B, NEXT_INS_ADR=8, PC_OUT=8 held; release -> C fetched next edge.
- PC_SRC=1, BRANCH_ADR=0x40, FLUSH=1 on one edge -> that edge gives IF_VALID=0, CUR_INS=0, PC_OUT=0x40; next edge gives CUR_INS=MEM[16], NEXT_INS_ADR=0x44. Repeat with STALL=1 also asserted -> same result.
- BRANCH_ADR=0x42, PC_SRC=1 -> next fetch edge gives ADR_ERR=1, IF_VALID=0, PC_OUT=0x42; further PC_SRC/STALL have no effect. Repeat with BRANCH_ADR=4*MEM_DEPTH -> same response. RST clears ADR_ERR and PC returns to RESET_PC.
- INS_WE writes word 5 = X in the same cycle PC=20 is fetched -> CUR_INS=old MEM[5]; after branching back to 20 -> CUR_INS=X.
- Assert RST mid-stream for half a cycle (asynchronously, off the clock edge) -> all outputs reset immediately without waiting for CLK; fetch restarts at RESET_PC.
